uart_rx_framer: RTL and testbench

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

---
 rtl/uart_rx_framer_pkg.sv | 22 ++
 rtl/uart_rx_framer_edge_bit_counter.sv | 38 +++
 rtl/uart_rx_framer.sv | 156 +++++++++++++++
 tb/tb_uart_rx_framer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_framer_pkg.sv
// Shared definitions for the UART receive framer: FSM state encoding,
// the legal oversampling rates and the 2-of-3 bit voter.
package uart_rx_framer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  // Majority of three mid-bit samples; a single noisy sample cannot flip a bit.
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_framer_edge_bit_counter.sv
// Edge counter (0..P-1 within a bit) and bit counter (bit index within the
// frame, start bit = 0). bit_end flags the last edge of the current bit.
module edge_bit_counter #(
  parameter int EDGE_W = 6,
  parameter int BIT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              run,
  input  logic [EDGE_W-1:0] prescale,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              bit_end
);

  assign bit_end = (edge_cnt == prescale - EDGE_W'(1));

  // The start cycle is edge 0, so the counter is loaded with 1; afterwards it
  // wraps at P-1 and each wrap advances the bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (start) begin
      edge_cnt <= EDGE_W'(1);
      bit_cnt  <= '0;
    end else if (run) begin
      if (bit_end) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + BIT_W'(1);
      end else begin
        edge_cnt <= edge_cnt + EDGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: oversampled start/data/parity/stop reception with
// majority-vote sampling, glitch rejection and one-cycle result strobes.
// RX_IN is expected to be already synchronous to CLK.
module uart_rx_framer
  import uart_rx_framer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VLD,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 3);

  state_e                  state_reg, state_next;
  logic [PRESCALE_W-1:0]   prescale_reg, prescale_legal, half;
  logic                    par_en_reg, par_typ_reg;
  logic [PRESCALE_W-1:0]   edge_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic                    bit_end;
  logic [2:0]              sample_reg;
  logic                    bit_val;
  logic [DATA_WIDTH-1:0]   shift_reg, p_data_reg;
  logic                    par_err_flag_reg;
  logic                    stp_err_flag;
  logic                    data_vld_reg, par_err_reg, stp_err_reg;
  logic                    start_frame, frame_end;

  assign half    = prescale_reg >> 1;
  assign bit_val = majority3(sample_reg);

  // Unsupported oversampling rates fall back to 8.
  always_comb begin
    prescale_legal = PRESCALE_W'(PRESCALE_8);
    if (PRESCALE == PRESCALE_W'(PRESCALE_16) || PRESCALE == PRESCALE_W'(PRESCALE_32))
      prescale_legal = PRESCALE;
  end

  edge_bit_counter #(
    .EDGE_W (PRESCALE_W),
    .BIT_W  (BIT_W)
  ) u_counter (
    .clk      (CLK),
    .rst_n    (RST),
    .start    (start_frame),
    .run      (state_reg != IDLE),
    .prescale (prescale_reg),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_end  (bit_end)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic; the strobe cycle is spent in IDLE so a new start bit
  // can be picked up immediately.
  always_comb begin
    state_next  = state_reg;
    start_frame = 1'b0;
    frame_end   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!RX_IN) begin
          start_frame = 1'b1;
          state_next  = START;
        end
      end
      START: begin
        if (bit_end) state_next = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end && bit_cnt == BIT_W'(DATA_WIDTH))
          state_next = par_en_reg ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          frame_end  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture three samples around mid-bit for the majority vote.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sample_reg <= '0;
    end else if (state_reg != IDLE) begin
      if (edge_cnt == half - PRESCALE_W'(1)) sample_reg[0] <= RX_IN;
      if (edge_cnt == half)                  sample_reg[1] <= RX_IN;
      if (edge_cnt == half + PRESCALE_W'(1)) sample_reg[2] <= RX_IN;
    end
  end

  assign stp_err_flag = ~bit_val;

  // Frame configuration latch, data shift register and parity check.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prescale_reg     <= '0;
      par_en_reg       <= 1'b0;
      par_typ_reg      <= 1'b0;
      shift_reg        <= '0;
      par_err_flag_reg <= 1'b0;
    end else if (start_frame) begin
      prescale_reg     <= prescale_legal;
      par_en_reg       <= PAR_EN;
      par_typ_reg      <= PAR_TYP;
      par_err_flag_reg <= 1'b0;
    end else if (bit_end) begin
      if (state_reg == DATA)
        shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
      if (state_reg == PARITY)
        par_err_flag_reg <= (bit_val != ((^shift_reg) ^ par_typ_reg));
    end
  end

  // Registered result strobes and the held output byte.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_data_reg   <= '0;
      data_vld_reg <= 1'b0;
      par_err_reg  <= 1'b0;
      stp_err_reg  <= 1'b0;
    end else begin
      data_vld_reg <= frame_end & ~par_err_flag_reg & ~stp_err_flag;
      par_err_reg  <= frame_end & par_err_flag_reg;
      stp_err_reg  <= frame_end & stp_err_flag;
      if (frame_end && !par_err_flag_reg && !stp_err_flag)
        p_data_reg <= shift_reg;
    end
  end

  assign P_DATA   = p_data_reg;
  assign DATA_VLD = data_vld_reg;
  assign PAR_ERR  = par_err_reg;
  assign STP_ERR  = stp_err_reg;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: a vector table of whole frames plus
// hand-written sequences for glitch, back-to-back and mid-frame reset.
module tb_uart_rx_framer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VLD;
  logic       PAR_ERR;
  logic       STP_ERR;

  uart_rx_framer dut (
    .CLK      (CLK),
    .RST      (RST),
    .RX_IN    (RX_IN),
    .PRESCALE (PRESCALE),
    .PAR_EN   (PAR_EN),
    .PAR_TYP  (PAR_TYP),
    .P_DATA   (P_DATA),
    .DATA_VLD (DATA_VLD),
    .PAR_ERR  (PAR_ERR),
    .STP_ERR  (STP_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Strobe monitor: counts high cycles of each strobe and when they occurred.
  int n_vld = 0;
  int n_par = 0;
  int n_stp = 0;
  int last_strobe = -1;
  int vld_cyc[$];
  always @(negedge CLK) begin
    if (DATA_VLD) begin
      n_vld = n_vld + 1;
      vld_cyc.push_back(cyc);
    end
    if (PAR_ERR) n_par = n_par + 1;
    if (STP_ERR) n_stp = n_stp + 1;
    if (DATA_VLD || PAR_ERR || STP_ERR) last_strobe = cyc;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame starting this cycle (cycle 0 = start bit's first cycle).
  // Returns in the cycle right after the stop bit, i.e. the strobe cycle.
  task automatic send_frame(input int bitlen, input logic [7:0] d, input bit pe,
                            input bit pb, input bit sb, input bit scramble,
                            output int t0);
    logic bits [11];
    int   nb;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[10] = 1'b1;
    if (pe) begin
      bits[9]  = pb;
      bits[10] = sb;
      nb = 11;
    end else begin
      bits[9] = sb;
      nb = 10;
    end
    t0 = cyc;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < bitlen; k++) begin
        RX_IN = bits[b];
        @(posedge CLK); #1;
        if (scramble && b == 0 && k == 0) begin
          PRESCALE = 6'd16;
          PAR_EN   = ~PAR_EN;
          PAR_TYP  = ~PAR_TYP;
        end
      end
    end
  endtask

  typedef struct {
    int         bitlen;
    logic [5:0] presc;
    bit         pe;
    bit         pt;
    logic [7:0] d;
    bit         pb;
    bit         sb;
    bit         scramble;
    int         exp_vld;
    int         exp_par;
    int         exp_stp;
    int         exp_lat;
    logic [7:0] exp_pdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int t0, t1, v0, p0, s0;
    logic [7:0] abort_d;

    //         bitlen presc pe pt data   pb sb scr vld par stp lat  pdata
    vecs[0] = '{8,  6'd8,  0, 0, 8'hA5, 0, 1, 0,  1,  0,  0,  80,  8'hA5};
    vecs[1] = '{16, 6'd16, 1, 0, 8'hA5, 0, 1, 0,  1,  0,  0,  176, 8'hA5};
    vecs[2] = '{16, 6'd16, 1, 0, 8'hA5, 1, 1, 0,  0,  1,  0,  176, 8'hA5};
    vecs[3] = '{32, 6'd32, 0, 0, 8'h3C, 0, 0, 0,  0,  0,  1,  320, 8'hA5};
    vecs[4] = '{8,  6'd8,  1, 1, 8'h01, 0, 1, 1,  1,  0,  0,  88,  8'h01};
    vecs[5] = '{8,  6'd8,  1, 1, 8'h01, 1, 0, 0,  0,  1,  1,  88,  8'h01};
    vecs[6] = '{8,  6'd12, 0, 0, 8'hC3, 0, 1, 0,  1,  0,  0,  80,  8'hC3};
    vecs[7] = '{32, 6'd32, 1, 0, 8'hFF, 0, 1, 0,  1,  0,  0,  352, 8'hFF};

    RST = 1'b0; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_pdata", {24'b0, P_DATA}, 32'h0);
    check("reset_vld", {31'b0, DATA_VLD}, 32'h0);
    check("reset_par", {31'b0, PAR_ERR}, 32'h0);
    check("reset_stp", {31'b0, STP_ERR}, 32'h0);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // Table-driven whole frames.
    for (int i = 0; i < 8; i++) begin
      PRESCALE = vecs[i].presc;
      PAR_EN   = vecs[i].pe;
      PAR_TYP  = vecs[i].pt;
      v0 = n_vld; p0 = n_par; s0 = n_stp;
      send_frame(vecs[i].bitlen, vecs[i].d, vecs[i].pe, vecs[i].pb, vecs[i].sb,
                 vecs[i].scramble, t0);
      RX_IN = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
      check($sformatf("vec%0d_vld", i), n_vld - v0, vecs[i].exp_vld);
      check($sformatf("vec%0d_par", i), n_par - p0, vecs[i].exp_par);
      check($sformatf("vec%0d_stp", i), n_stp - s0, vecs[i].exp_stp);
      check($sformatf("vec%0d_cycle", i), last_strobe - t0, vecs[i].exp_lat);
      check($sformatf("vec%0d_pdata", i), {24'b0, P_DATA}, {24'b0, vecs[i].exp_pdata});
      $display("vec %0d P=%0d pe=%0d pt=%0d data=%02h: vld=%0d par=%0d stp=%0d at %0d pdata=%02h",
               i, vecs[i].presc, vecs[i].pe, vecs[i].pt, vecs[i].d, n_vld - v0,
               n_par - p0, n_stp - s0, last_strobe - t0, P_DATA);
    end

    // Short low glitch followed by a real frame starting exactly at cycle 16.
    PRESCALE = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    v0 = n_vld; p0 = n_par; s0 = n_stp;
    t0 = cyc;
    RX_IN = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    RX_IN = 1'b1;
    repeat (14) begin @(posedge CLK); #1; end
    send_frame(16, 8'h96, 1'b0, 1'b0, 1'b1, 1'b0, t1);
    RX_IN = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    check("glitch_vld", n_vld - v0, 1);
    check("glitch_err", (n_par - p0) + (n_stp - s0), 0);
    if (n_vld - v0 >= 1) check("glitch_cycle", vld_cyc[v0] - t0, 16 + 160);
    check("glitch_pdata", {24'b0, P_DATA}, 32'h96);
    $display("glitch: strobes=%0d pdata=%02h", n_vld - v0, P_DATA);

    // Back-to-back frames with no idle gap.
    PRESCALE = 6'd8;
    v0 = n_vld;
    send_frame(8, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    #1;
    check("b2b_first_vld", {31'b0, DATA_VLD}, 32'h1);
    check("b2b_first_pdata", {24'b0, P_DATA}, 32'h11);
    send_frame(8, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, t1);
    RX_IN = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    check("b2b_count", n_vld - v0, 2);
    if (n_vld - v0 >= 2) begin
      check("b2b_cycle1", vld_cyc[v0] - t0, 80);
      check("b2b_cycle2", vld_cyc[v0+1] - t0, 160);
    end
    check("b2b_pdata", {24'b0, P_DATA}, 32'h22);
    $display("back-to-back: strobes=%0d pdata=%02h", n_vld - v0, P_DATA);

    // Reset at cycle 40 of a frame, then a fresh frame.
    v0 = n_vld; p0 = n_par; s0 = n_stp;
    abort_d = 8'hA5;
    for (int c = 0; c < 40; c++) begin
      RX_IN = (c < 8) ? 1'b0 : abort_d[(c / 8) - 1];
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    #1;
    check("abort_async_pdata", {24'b0, P_DATA}, 32'h0);
    check("abort_async_vld", {31'b0, DATA_VLD}, 32'h0);
    RX_IN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    send_frame(8, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, t0);
    RX_IN = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    check("abort_vld", n_vld - v0, 1);
    check("abort_err", (n_par - p0) + (n_stp - s0), 0);
    if (n_vld - v0 >= 1) check("abort_cycle", vld_cyc[v0] - t0, 80);
    check("abort_pdata", {24'b0, P_DATA}, 32'h5A);
    $display("reset-abort: strobes=%0d pdata=%02h", n_vld - v0, P_DATA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
